// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external ALU between two requesters.
// Each operation is latched on handshake, held through EXEC/RESP, and answered with a one-cycle pulse.
module alu_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [5:0]  req_op,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_carry,
    output logic        rsp_zero,
    output logic [31:0] alu_data1,
    output logic [31:0] alu_data2,
    output logic [2:0]  alu_ctrl,
    input  logic [31:0] alu_out,
    input  logic        alu_carry
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(ALU_LAT - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       last_grant;
    logic       grant_id;
    logic       active_id;

    // With both requesters valid the one not served last wins; otherwise the lone valid one wins.
    always_comb begin
        grant_id  = 1'b0;
        req_ready = 2'b00;
        if (req_valid == 2'b11) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req_valid[1];
        end
        if (rst_n && (state == IDLE) && (req_valid != 2'b00)) begin
            req_ready = grant_id ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_grant <= 1'b1;
            active_id  <= 1'b0;
            rsp_valid  <= 2'b00;
            rsp_data   <= 32'd0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            alu_data1  <= 32'd0;
            alu_data2  <= 32'd0;
            alu_ctrl   <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 2'b00;
                    if (req_ready != 2'b00) begin
                        alu_ctrl   <= grant_id ? req_op[5:3]  : req_op[2:0];
                        alu_data1  <= grant_id ? req_a[63:32] : req_a[31:0];
                        alu_data2  <= grant_id ? req_b[63:32] : req_b[31:0];
                        active_id  <= grant_id;
                        last_grant <= grant_id;
                        cnt        <= 4'd0;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    // The ALU output is only trusted on the final EXEC cycle.
                    if (cnt == CNT_LAST) begin
                        rsp_data  <= alu_out;
                        rsp_zero  <= (alu_out == 32'd0);
                        rsp_carry <= ((alu_ctrl == 3'b000) || (alu_ctrl == 3'b001)) & alu_carry;
                        rsp_valid <= active_id ? 2'b10 : 2'b01;
                        cnt       <= 4'd0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP: begin
                    rsp_valid <= 2'b00;
                    state     <= IDLE;
                end
                default: begin
                    rsp_valid <= 2'b00;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (ALU_LAT 1 and 3) with a behavioural ALU,
// checked every cycle against a cycle-count/queue model plus directed scenarios.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  valid_s [2];
    logic [1:0]  ready_s [2];
    logic [5:0]  op_s    [2];
    logic [63:0] a_s     [2];
    logic [63:0] b_s     [2];
    logic [1:0]  rspv_s  [2];
    logic [31:0] data_s  [2];
    logic        carry_s [2];
    logic        zero_s  [2];
    logic [31:0] ad1_s   [2];
    logic [31:0] ad2_s   [2];
    logic [2:0]  actl_s  [2];
    logic [31:0] aout_s  [2];
    logic        acar_s  [2];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Model state, one slot per instance
    int          free_at [2];
    bit          last    [2];
    bit          pend    [2];
    int          due     [2];
    bit          pid     [2];
    logic [31:0] pdata   [2];
    bit          pcar    [2];
    bit          pzero   [2];
    logic [31:0] hdata   [2];
    bit          hcar    [2];
    bit          hzero   [2];
    logic [31:0] ea      [2];
    logic [31:0] eb      [2];
    logic [2:0]  eop     [2];
    bit          gq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // External ALU: carry is deliberately noisy for ops that must not report it.
    function automatic logic [32:0] tb_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return {1'b0, a} + {1'b0, b};
            3'b001:  return {a < b, a - b};
            3'b010:  return {~a[0], a & b};
            3'b011:  return {~a[0], a ^ b};
            3'b100:  return {~a[0], a | b};
            default: return {~a[0], a};
        endcase
    endfunction

    function automatic logic [32:0] spec_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        case (op)
            3'b000:  return sum;
            3'b001:  return {a < b, a - b};
            3'b010:  return {1'b0, a & b};
            3'b011:  return {1'b0, a ^ b};
            3'b100:  return {1'b0, a | b};
            default: return {1'b0, a};
        endcase
    endfunction

    assign {acar_s[0], aout_s[0]} = tb_alu(actl_s[0], ad1_s[0], ad2_s[0]);
    assign {acar_s[1], aout_s[1]} = tb_alu(actl_s[1], ad1_s[1], ad2_s[1]);

    alu_arbiter #(.ALU_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid_s[0]), .req_ready(ready_s[0]),
        .req_op(op_s[0]), .req_a(a_s[0]), .req_b(b_s[0]), .rsp_valid(rspv_s[0]),
        .rsp_data(data_s[0]), .rsp_carry(carry_s[0]), .rsp_zero(zero_s[0]),
        .alu_data1(ad1_s[0]), .alu_data2(ad2_s[0]), .alu_ctrl(actl_s[0]),
        .alu_out(aout_s[0]), .alu_carry(acar_s[0])
    );

    alu_arbiter #(.ALU_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid_s[1]), .req_ready(ready_s[1]),
        .req_op(op_s[1]), .req_a(a_s[1]), .req_b(b_s[1]), .rsp_valid(rspv_s[1]),
        .rsp_data(data_s[1]), .rsp_carry(carry_s[1]), .rsp_zero(zero_s[1]),
        .alu_data1(ad1_s[1]), .alu_data2(ad2_s[1]), .alu_ctrl(actl_s[1]),
        .alu_out(aout_s[1]), .alu_carry(acar_s[1])
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic apply_stimulus(input int k, input int id, input logic [2:0] op,
                                  input logic [31:0] a, input logic [31:0] b);
        if (id == 0) begin
            op_s[k][2:0] = op;
            a_s[k][31:0] = a;
            b_s[k][31:0] = b;
        end else begin
            op_s[k][5:3]  = op;
            a_s[k][63:32] = a;
            b_s[k][63:32] = b;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle prediction: the arbiter is free again ALU_LAT+2 cycles after a handshake,
    // and the answer appears ALU_LAT+1 cycles after it.
    task automatic model_step(input int k);
        int          lat;
        logic [1:0]  v;
        logic [1:0]  er;
        logic [1:0]  erv;
        bit          win;
        logic [32:0] r;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        string       pfx;
        lat = (k == 0) ? 1 : 3;
        pfx = (k == 0) ? "lat1" : "lat3";
        er  = 2'b00;
        erv = 2'b00;
        win = 1'b0;
        v   = valid_s[k];
        if (!rst_n) begin
            pend[k] = 0; last[k] = 1; free_at[k] = 0;
            hdata[k] = 32'd0; hcar[k] = 0; hzero[k] = 0;
            ea[k] = 32'd0; eb[k] = 32'd0; eop[k] = 3'd0;
        end else if (cyc >= free_at[k] && v != 2'b00) begin
            if (v == 2'b11) win = !last[k];
            else if (v == 2'b10) win = 1'b1;
            else win = 1'b0;
            er = win ? 2'b10 : 2'b01;
        end
        if (pend[k] && due[k] == cyc) begin
            erv = pid[k] ? 2'b10 : 2'b01;
            hdata[k] = pdata[k]; hcar[k] = pcar[k]; hzero[k] = pzero[k];
            pend[k] = 0;
        end
        check_output({pfx, "_req_ready"}, 32'(ready_s[k]), 32'(er));
        check_output({pfx, "_rsp_valid"}, 32'(rspv_s[k]), 32'(erv));
        check_output({pfx, "_rsp_data"},  data_s[k], hdata[k]);
        check_output({pfx, "_rsp_carry"}, 32'(carry_s[k]), 32'(hcar[k]));
        check_output({pfx, "_rsp_zero"},  32'(zero_s[k]), 32'(hzero[k]));
        check_output({pfx, "_alu_data1"}, ad1_s[k], ea[k]);
        check_output({pfx, "_alu_data2"}, ad2_s[k], eb[k]);
        check_output({pfx, "_alu_ctrl"},  32'(actl_s[k]), 32'(eop[k]));
        if (er != 2'b00) begin
            op = win ? op_s[k][5:3]  : op_s[k][2:0];
            a  = win ? a_s[k][63:32] : a_s[k][31:0];
            b  = win ? b_s[k][63:32] : b_s[k][31:0];
            r  = spec_res(op, a, b);
            pend[k] = 1; pid[k] = win;
            due[k] = cyc + lat + 1; free_at[k] = cyc + lat + 2;
            last[k] = win;
            pdata[k] = r[31:0]; pcar[k] = r[32]; pzero[k] = (r[31:0] == 32'd0);
            ea[k] = a; eb[k] = b; eop[k] = op;
            if (k == 0) gq.push_back(win);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
    end

    task automatic wait_rsp(input int k, input int id, input logic [31:0] ed,
                            input bit ec, input bit ez, input string tag);
        bit found;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (rspv_s[k][id]) found = 1;
        end
        check_output({tag, "_seen"}, 32'(found), 32'd1);
        if (found) begin
            check_output({tag, "_data"},  data_s[k], ed);
            check_output({tag, "_carry"}, 32'(carry_s[k]), 32'(ec));
            check_output({tag, "_zero"},  32'(zero_s[k]), 32'(ez));
        end
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 3));
            1:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int hs_cyc;
        for (int k = 0; k < 2; k++) begin
            valid_s[k] = 2'b00; op_s[k] = 6'd0; a_s[k] = 64'd0; b_s[k] = 64'd0;
        end
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Wrapping add on the single-cycle ALU
        apply_stimulus(0, 0, 3'b000, 32'hFFFF_FFFF, 32'h1);
        valid_s[0] = 2'b01;
        @(negedge clk);
        check_output("add_wrap_ready", 32'(ready_s[0]), 32'h1);
        step();
        valid_s[0] = 2'b00;
        wait_rsp(0, 0, 32'h0, 1'b1, 1'b1, "add_wrap");
        repeat (3) step();

        // Contested requests alternate after reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        gq.delete();
        apply_stimulus(0, 0, 3'b001, 32'd5, 32'd5);
        apply_stimulus(0, 1, 3'b100, 32'hF0, 32'h0F);
        valid_s[0] = 2'b11;
        wait_rsp(0, 0, 32'h0,  1'b0, 1'b1, "rr_sub0");
        wait_rsp(0, 1, 32'hFF, 1'b0, 1'b0, "rr_or1");
        wait_rsp(0, 0, 32'h0,  1'b0, 1'b1, "rr_sub0b");
        wait_rsp(0, 1, 32'hFF, 1'b0, 1'b0, "rr_or1b");
        step();
        valid_s[0] = 2'b00;
        check_output("rr_grant_count", 32'(gq.size()), 32'd4);
        for (int i = 0; i < 4 && i < gq.size(); i++) begin
            check_output("rr_grant_order", 32'(gq[i]), 32'(i % 2));
        end
        repeat (3) step();

        // Pass-through op from requester 1 alone
        apply_stimulus(0, 1, 3'b111, 32'h1234, 32'hFFFF);
        valid_s[0] = 2'b10;
        step();
        valid_s[0] = 2'b00;
        wait_rsp(0, 1, 32'h1234, 1'b0, 1'b0, "pass_a");
        repeat (3) step();

        // Three-cycle ALU, operands disturbed while executing
        apply_stimulus(1, 0, 3'b011, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
        valid_s[1] = 2'b01;
        hs_cyc = cyc;
        step();
        valid_s[1] = 2'b00;
        apply_stimulus(1, 0, 3'b000, 32'h1111_1111, 32'h0);
        apply_stimulus(1, 1, 3'b001, 32'h2222_2222, 32'h3);
        wait_rsp(1, 0, 32'h5A5A_5A5A, 1'b0, 1'b0, "xor_lat3");
        check_output("xor_lat3_latency", 32'(cyc - hs_cyc), 32'd4);
        repeat (3) step();

        // Reset in the middle of EXEC drops the operation
        apply_stimulus(1, 0, 3'b000, 32'd7, 32'd8);
        valid_s[1] = 2'b01;
        step();
        valid_s[1] = 2'b00;
        step();
        rst_n = 1'b0;
        apply_stimulus(1, 0, 3'b010, 32'hF0F0, 32'h0FF0);
        valid_s[1] = 2'b01;
        @(negedge clk);
        check_output("rst_rsp_valid", 32'(rspv_s[1]), 32'h0);
        check_output("rst_rsp_data", data_s[1], 32'h0);
        check_output("rst_alu_data1", ad1_s[1], 32'h0);
        check_output("rst_req_ready", 32'(ready_s[1]), 32'h0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check_output("rst_first_ready", 32'(ready_s[1]), 32'h1);
        step();
        valid_s[1] = 2'b00;
        wait_rsp(1, 0, 32'h00F0, 1'b0, 1'b0, "and_after_rst");
        repeat (3) step();

        // Random traffic on both instances with one reset pulse in the middle
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++) begin
                valid_s[k] = 2'($urandom_range(0, 3));
                for (int id = 0; id < 2; id++) begin
                    apply_stimulus(k, id, 3'($urandom_range(0, 7)), rand_word(), rand_word());
                end
            end
            rst_n = (n != 200);
            step();
        end
        rst_n = 1'b1;
        valid_s[0] = 2'b00;
        valid_s[1] = 2'b00;
        repeat (8) step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
